// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length/payload/checksum byte frame,
// writes little-endian 32-bit words into imem and releases the core on a clean load.
module imem_loader #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 imem_we,
  output logic [WORD_SIZE-1:0] imem_addr,
  output logic [WORD_SIZE-1:0] imem_wdata,
  output logic                 core_run,
  output logic                 done,
  output logic                 error
);

  localparam int WIDX_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            csum_q, csum_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
  logic [23:0]           word_q, word_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [WORD_SIZE-1:0]  imem_addr_q, imem_addr_d;
  logic [WORD_SIZE-1:0]  imem_wdata_q, imem_wdata_d;
  logic                  core_run_q, core_run_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  hs;
  logic [15:0]           len_full;
  logic [WIDX_W-1:0]     word_idx_inc;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    csum_d       = csum_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    hs           = byte_valid && byte_ready_q;
    len_full     = {byte_data, len_q[7:0]};
    word_idx_inc = word_idx_q + WIDX_W'(1);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          len_d      = '0;
          csum_d     = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          word_d     = '0;
        end
      end
      S_LEN_LO: begin
        if (hs) begin
          len_d[7:0] = byte_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          len_d[15:8] = byte_data;
          if (len_full == 16'd0 || 17'(len_full) > 17'(DEPTH)) state_d = S_ERROR;
          else                                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          csum_d     = csum_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              // Last byte goes straight to the write port; no stall needed.
              imem_we_d    = 1'b1;
              imem_addr_d  = WORD_SIZE'({word_idx_q, 2'b00});
              imem_wdata_d = WORD_SIZE'({byte_data, word_q});
              word_idx_d   = word_idx_inc;
              if (16'(word_idx_inc) == len_q) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (hs) state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with state_q.
    byte_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
    done_d       = (state_d == S_DONE);
    core_run_d   = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      csum_q       <= '0;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_run_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_run_q   <= core_run_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_run   = core_run_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
